// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  // Scheduler phases: waiting for a requester, forwarding a packet, discarding an aborted packet.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  // Baud-select codes understood by the baud generator.
  localparam logic [1:0] BAUD_SEL_0 = 2'b00;
  localparam logic [1:0] BAUD_SEL_1 = 2'b01;
  localparam logic [1:0] BAUD_SEL_2 = 2'b10;
  localparam logic [1:0] BAUD_SEL_3 = 2'b11;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] w_cand;

  // Scan offsets from farthest to nearest so the nearest set request after ptr overwrites the rest.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int k = N; k >= 1; k--) begin
      w_cand = IW'((int'(ptr) + k) % N);
      if (req[w_cand]) begin
        onehot         = '0;
        onehot[w_cand] = 1'b1;
        idx            = w_cand;
        any            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART Tx path among NUM_REQ byte-stream requesters, packet by packet,
// with round-robin fairness, stall abort and between-packet baud changes.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_SIZE = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WIDTH_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [1:0]                    cfg_sel,
  output logic [1:0]                    baud_sel,
  output logic                          tx_valid,
  output logic [WIDTH_SIZE-1:0]         tx_data,
  input  logic                          tx_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int              IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0]   PTR_INIT = IW'(NUM_REQ - 1);

  sched_state_t        r_state, w_state_next;
  logic [NUM_REQ-1:0]  r_grant, w_grant_next;
  logic [IW-1:0]       r_owner, w_owner_next;
  logic [IW-1:0]       r_ptr, w_ptr_next;
  logic [CW-1:0]       r_cnt, w_cnt_next;
  logic                r_timeout_err, w_timeout_err_next;
  logic [1:0]          r_baud_sel, w_baud_sel_next;

  logic [NUM_REQ-1:0]    w_arb_onehot;
  logic [IW-1:0]         w_arb_idx;
  logic                  w_arb_any;
  logic [WIDTH_SIZE-1:0] w_req_bytes [NUM_REQ];
  logic                  w_own_valid;
  logic                  w_own_last;
  logic                  w_xfer;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_bytes[gi] = req_data[gi*WIDTH_SIZE +: WIDTH_SIZE];
    end
  endgenerate

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req    (req_valid),
    .ptr    (r_ptr),
    .onehot (w_arb_onehot),
    .idx    (w_arb_idx),
    .any    (w_arb_any)
  );

  assign w_own_valid = req_valid[r_owner];
  assign w_own_last  = req_last[r_owner];
  assign w_xfer      = (r_state == SEND) && w_own_valid && tx_ready;

  assign grant       = r_grant;
  assign busy        = (r_state != IDLE);
  assign timeout_err = r_timeout_err;
  assign baud_sel    = r_baud_sel;

  // Datapath decode: forward the owner's byte straight through while sending, swallow it while draining.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    case (r_state)
      SEND: begin
        tx_valid  = w_own_valid;
        tx_data   = w_req_bytes[r_owner];
        req_ready = r_grant & {NUM_REQ{tx_ready}};
      end
      DRAIN: begin
        req_ready = r_grant;
      end
      default: ;
    endcase
  end

  // Next-state logic: arbitrate in IDLE, hold the grant through req_last, abort on a long stall.
  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_owner_next       = r_owner;
    w_ptr_next         = r_ptr;
    w_cnt_next         = r_cnt;
    w_timeout_err_next = 1'b0;
    w_baud_sel_next    = r_baud_sel;
    case (r_state)
      IDLE: begin
        w_baud_sel_next = cfg_sel;
        w_cnt_next      = '0;
        if (w_arb_any) begin
          w_state_next = SEND;
          w_grant_next = w_arb_onehot;
          w_owner_next = w_arb_idx;
        end
      end
      SEND: begin
        if (w_xfer) begin
          w_cnt_next = '0;
          if (w_own_last) begin
            w_state_next = IDLE;
            w_ptr_next   = r_owner;
            w_grant_next = '0;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_err_next = 1'b1;
          w_state_next       = DRAIN;
          w_cnt_next         = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (w_own_valid && w_own_last) begin
          w_state_next = IDLE;
          w_ptr_next   = r_owner;
          w_grant_next = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  // State register; the last-winner pointer starts at NUM_REQ-1 so requester 0 is served first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_ptr         <= PTR_INIT;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
      r_baud_sel    <= BAUD_SEL_0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_owner       <= w_owner_next;
      r_ptr         <= w_ptr_next;
      r_cnt         <= w_cnt_next;
      r_timeout_err <= w_timeout_err_next;
      r_baud_sel    <= w_baud_sel_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: per-requester packet queues drive the DUT,
// a packet-level reference model predicts ownership, bytes, baud select and aborts.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 4096;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [1:0]     cfg_sel;
  logic [1:0]     baud_sel;
  logic           tx_valid;
  logic [W-1:0]   tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(N), .WIDTH_SIZE(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .cfg_sel     (cfg_sel),
    .baud_sel    (baud_sel),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Each requester's pending bytes: {last, data}.
  logic [8:0] q [N][$];
  logic [N-1:0] en;
  logic [N-1:0] hs;
  bit   gate;
  int   ready_mode;   // 0 low, 1 high, 2 toggle, 3 random
  logic tog;

  // Reference model: current owner (-1 when idle), abort flag, last winner, stall count.
  int         m_owner;
  bit         m_abort;
  int         m_ptr;
  int         m_stall;
  logic [1:0] m_baud;
  bit         m_terr;

  int terr_count  = 0;
  int xfer_count  = 0;
  int drain_count = 0;
  int win_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_abort = 0;
    m_ptr   = N - 1;
    m_stall = 0;
    m_baud  = 2'b00;
    m_terr  = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0 && en[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = q[i][0][7:0];
        req_last[i]        = q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
      end
    end
    case (ready_mode)
      0: tx_ready = 1'b0;
      1: tx_ready = 1'b1;
      2: begin tx_ready = tog; tog = ~tog; end
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic monitor();
    int g;
    hs = '0;
    if (reset) return;
    if (timeout_err) terr_count++;
    check("timeout_err", timeout_err, m_terr);
    m_terr = 0;
    check("baud_sel", baud_sel, m_baud);
    if (m_owner < 0) begin
      check("idle_grant", grant, 0);
      check("idle_busy", busy, 0);
      check("idle_tx_valid", tx_valid, 0);
      check("idle_req_ready", req_ready, 0);
      m_baud = cfg_sel;
      if (req_valid != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (req_valid[c]) begin
            m_owner = c;
            break;
          end
        end
        m_abort = 0;
        m_stall = 0;
        win_log.push_back(m_owner);
      end
    end else begin
      g = m_owner;
      check("own_grant", grant, 1 << g);
      check("own_busy", busy, 1);
      if (!m_abort) begin
        check("send_tx_valid", tx_valid, req_valid[g]);
        if (req_valid[g]) check("send_tx_data", tx_data, q[g][0][7:0]);
        check("send_req_ready", req_ready, tx_ready ? (1 << g) : 0);
        if (req_valid[g] && tx_ready) begin
          hs[g] = 1'b1;
          xfer_count++;
          m_stall = 0;
          if (req_last[g]) begin
            m_owner = -1;
            m_ptr   = g;
          end
        end else begin
          m_stall++;
          if (m_stall == TO) begin
            m_abort = 1;
            m_terr  = 1;
          end
        end
      end else begin
        check("drain_tx_valid", tx_valid, 0);
        check("drain_req_ready", req_ready, 1 << g);
        if (req_valid[g]) begin
          hs[g] = 1'b1;
          drain_count++;
          if (req_last[g]) begin
            m_owner = -1;
            m_ptr   = g;
          end
        end
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check settled outputs, retire handshakes after the rise.
  task automatic step();
    for (int i = 0; i < N; i++) en[i] = gate ? ($urandom_range(0, 3) != 0) : 1'b1;
    drive();
    #1;
    monitor();
    @(negedge clk);
    if (reset) model_reset();
    else for (int i = 0; i < N; i++) if (hs[i]) void'(q[i].pop_front());
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_pkt(input int r, input int len);
    for (int b = 0; b < len; b++) q[r].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
  endtask

  task automatic run_until_done(input int max_cycles, input string tag, output int n);
    n = 0;
    while ((m_owner >= 0 || pending()) && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_bounded"}, (n < max_cycles), 1);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < N; i++) q[i].delete();
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  int n, base_x, base_d, base_t, total, guard;

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    cfg_sel = 2'b00; tx_ready = 1'b0; gate = 0; ready_mode = 1; tog = 1'b1; en = '1;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Reset state
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_baud_sel", baud_sel, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_req_ready", req_ready, 0);
    repeat (2) step();

    // 1: single 3-byte packet, one arbitration cycle then three back-to-back bytes
    base_x = xfer_count;
    q[0].push_back({1'b0, 8'hA1}); q[0].push_back({1'b0, 8'hA2}); q[0].push_back({1'b1, 8'hA3});
    run_until_done(20, "t1", n);
    check("t1_cycles", n, 4);
    check("t1_bytes", xfer_count - base_x, 3);
    step();

    // 2: req0 (two packets) and req2 contend from a fresh pointer: 0, 2, 0
    do_reset(1);
    win_log.delete();
    push_pkt(0, 2); push_pkt(0, 2); push_pkt(2, 2);
    run_until_done(40, "t2", n);
    check("t2_wins", win_log.size(), 3);
    if (win_log.size() == 3) begin
      check("t2_win0", win_log[0], 0);
      check("t2_win1", win_log[1], 2);
      check("t2_win2", win_log[2], 0);
    end
    step();

    // 3: Tx path stuck low -> single abort pulse, packet drained without tx_valid
    base_x = xfer_count; base_d = drain_count; base_t = terr_count;
    ready_mode = 0;
    push_pkt(1, 3);
    run_until_done(TO + 50, "t3", n);
    repeat (3) step();
    check("t3_pulses", terr_count - base_t, 1);
    check("t3_drained", drain_count - base_d, 3);
    check("t3_sent", xfer_count - base_x, 0);
    check("t3_idle", busy, 0);

    // 4: baud change requested mid-packet is deferred to the next IDLE
    ready_mode = 3;
    cfg_sel = 2'b00;
    step();
    push_pkt(3, 8);
    guard = 0;
    while (m_owner != 3 && guard < 10) begin step(); guard++; end
    check("t4_granted", m_owner, 3);
    step();
    cfg_sel = 2'b10;
    step();
    check("t4_frozen", baud_sel, 2'b00);
    run_until_done(200, "t4", n);
    repeat (2) step();
    check("t4_baud", baud_sel, 2'b10);

    // 5: reset after byte 1 of 4 on req0, with ptr already past req0
    ready_mode = 1;
    push_pkt(0, 1);
    run_until_done(10, "t5a", n);
    step();
    base_x = xfer_count;
    push_pkt(0, 4);
    guard = 0;
    while (xfer_count == base_x && guard < 10) begin step(); guard++; end
    check("t5_first_byte", xfer_count - base_x, 1);
    do_reset(1);
    check("t5_tx_valid", tx_valid, 0);
    check("t5_grant", grant, 0);
    check("t5_busy", busy, 0);
    win_log.delete();
    push_pkt(1, 1); push_pkt(0, 1);
    run_until_done(20, "t5b", n);
    check("t5_winner", (win_log.size() > 0) ? win_log[0] : -1, 0);
    step();

    // 6: tx_ready toggling, random packets and gaps on every requester
    ready_mode = 2; gate = 1;
    base_x = xfer_count; base_t = terr_count; total = 0;
    for (int r = 0; r < N; r++) begin
      for (int p = 0; p < 2; p++) begin
        int len;
        len = $urandom_range(1, 5);
        push_pkt(r, len);
        total += len;
      end
    end
    run_until_done(2000, "t6", n);
    repeat (2) step();
    check("t6_bytes", xfer_count - base_x, total);
    check("t6_no_abort", terr_count - base_t, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
